// File: rtl/ppm_decoder.sv
// ---------------------------------------------------------------------------
// ppm_decoder
// Recovers the pulse position of each PPM frame from a single-wire stream.
// Frame timing comes from a frame-start strobe or from a free-running
// counter. A good frame (exactly one accepted pulse) updates pos_out with a
// one-cycle pos_valid strobe. Frames with no pulse or with several pulses
// raise err_missing / err_multi instead.
//
// Optional feature macro: PPM_DEC_SYNC_EN
//   defined   : 2-flop synchronizer on ppm_in and a matching 2-cycle delay
//               on sync_in (latency L = 2). Use when ppm_in is asynchronous.
//   undefined : ppm_in / sync_in used directly (L = 0). ppm_in must be
//               driven from clk.
//
// Parameters
//   FRAME_LEN  cycles per frame (4 .. 2**CNT_W)
//   CNT_W      width of the position counter and pos_out
//   MIN_WIDTH  minimum consecutive high cycles for a pulse (>= 1)
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   ena          in   clock enable; low holds all state, clears strobes
//   ppm_in       in   pulse stream
//   sync_in      in   frame-start strobe (its cycle is position 0)
//   pos_out      out  last successfully decoded position
//   pos_valid    out  one-cycle strobe when pos_out updates
//   err_missing  out  one-cycle strobe: frame ended with no pulse
//   err_multi    out  one-cycle strobe: frame ended with 2+ pulses
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ppm_decoder #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             ppm_in,
  input  logic             sync_in,
  output logic [CNT_W-1:0] pos_out,
  output logic             pos_valid,
  output logic             err_missing,
  output logic             err_multi
);

  localparam int unsigned       WID_W          = (MIN_WIDTH < 2) ? 1 : $clog2(MIN_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_POS       = CNT_W'(FRAME_LEN - 1);
  localparam logic [WID_W-1:0]  WID_MAX        = WID_W'(MIN_WIDTH);
  localparam bit                ACCEPT_ON_RISE = (MIN_WIDTH == 1);
  localparam logic [1:0]        HITS_NONE      = 2'd0;
  localparam logic [1:0]        HITS_ONE       = 2'd1;
  localparam logic [1:0]        HITS_MANY      = 2'd2;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_CHK  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  logic             w_ppm_s;
  logic             w_sync_d;

  // Input stage: ppm and sync see the same delay so positions stay aligned
`ifdef PPM_DEC_SYNC_EN
  logic r_ppm_meta;
  logic r_ppm_s;
  logic r_sync_d1;
  logic r_sync_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ppm_meta <= 1'b0;
      r_ppm_s    <= 1'b0;
      r_sync_d1  <= 1'b0;
      r_sync_d2  <= 1'b0;
    end else if (ena) begin
      r_ppm_meta <= ppm_in;
      r_ppm_s    <= r_ppm_meta;
      r_sync_d1  <= sync_in;
      r_sync_d2  <= r_sync_d1;
    end
  end

  assign w_ppm_s  = r_ppm_s;
  assign w_sync_d = r_sync_d2;
`else
  assign w_ppm_s  = ppm_in;
  assign w_sync_d = sync_in;
`endif

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_pos_now;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_frame_end;
  logic             w_abort;

  // Frame position: sync forces position 0; an unaligned sync aborts the frame
  assign w_pos_now   = w_sync_d ? '0 : r_cnt;
  assign w_frame_end = (w_pos_now == LAST_POS);
  assign w_abort     = w_sync_d && (r_cnt != '0);
  assign w_cnt_nxt   = w_frame_end ? '0 : (w_pos_now + CNT_W'(1));

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WID_W-1:0] r_width;
  logic [WID_W-1:0] w_width_inc;
  logic [WID_W-1:0] w_width_nxt;
  logic [CNT_W-1:0] r_cand;
  logic [CNT_W-1:0] w_acc_pos;
  logic             w_capture;
  logic             w_accept;

  assign w_width_inc = r_width + WID_W'(1);

  // Pulse FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOW;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  // Pulse FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOW: begin
        if (w_ppm_s) begin
          w_state_nxt = ACCEPT_ON_RISE ? S_HIGH : S_CHK;
        end
      end
      S_CHK: begin
        if (!w_ppm_s) begin
          w_state_nxt = S_LOW;
        end else if (w_width_inc == WID_MAX) begin
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (!w_ppm_s) begin
          w_state_nxt = S_LOW;
        end
      end
      default: w_state_nxt = S_LOW;
    endcase
  end

  // Pulse FSM: outputs (capture on rise, accept once width reaches MIN_WIDTH)
  always_comb begin
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    w_width_nxt = r_width;
    w_acc_pos   = r_cand;
    case (r_state)
      S_LOW: begin
        w_acc_pos = w_pos_now;
        if (w_ppm_s) begin
          w_capture   = 1'b1;
          w_width_nxt = WID_W'(1);
          w_accept    = ACCEPT_ON_RISE;
        end
      end
      S_CHK: begin
        if (w_ppm_s) begin
          w_width_nxt = w_width_inc;
          w_accept    = (w_width_inc == WID_MAX);
        end
      end
      default: ;
    endcase
  end

  logic [1:0]       r_hits;
  logic [1:0]       w_hits_base;
  logic [1:0]       w_hits_eff;
  logic [CNT_W-1:0] r_first;
  logic [CNT_W-1:0] w_first_eff;

  // Hit tally including an accept in this very cycle; an abort starts from zero
  assign w_hits_base = w_abort ? HITS_NONE : r_hits;
  assign w_hits_eff  = !w_accept ? w_hits_base :
                       (w_hits_base == HITS_NONE) ? HITS_ONE : HITS_MANY;
  assign w_first_eff = (w_accept && (w_hits_base == HITS_NONE)) ? w_acc_pos : r_first;

  // Counter, candidate/width tracking, frame evaluation and output strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_cand      <= '0;
      r_width     <= '0;
      r_hits      <= HITS_NONE;
      r_first     <= '0;
      pos_out     <= '0;
      pos_valid   <= 1'b0;
      err_missing <= 1'b0;
      err_multi   <= 1'b0;
    end else if (!ena) begin
      pos_valid   <= 1'b0;
      err_missing <= 1'b0;
      err_multi   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_width     <= w_width_nxt;
      pos_valid   <= 1'b0;
      err_missing <= 1'b0;
      err_multi   <= 1'b0;
      if (w_capture) begin
        r_cand <= w_pos_now;
      end
      if (w_frame_end) begin
        pos_valid   <= (w_hits_eff == HITS_ONE);
        err_missing <= (w_hits_eff == HITS_NONE);
        err_multi   <= (w_hits_eff == HITS_MANY);
        if (w_hits_eff == HITS_ONE) begin
          pos_out <= w_first_eff;
        end
        r_hits <= HITS_NONE;
      end else begin
        r_hits  <= w_hits_eff;
        r_first <= w_first_eff;
      end
    end
  end

endmodule

// File: tb/tb_ppm_decoder.sv
`timescale 1ns/1ps

module tb_ppm_decoder;

`ifdef PPM_DEC_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       ppm_in;
  logic       sync_in;
  logic [7:0] pos_out;
  logic       pos_valid;
  logic       err_missing;
  logic       err_multi;

  always #5 clk = ~clk;

  ppm_decoder #(
    .FRAME_LEN(256),
    .CNT_W    (8),
    .MIN_WIDTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .ppm_in     (ppm_in),
    .sync_in    (sync_in),
    .pos_out    (pos_out),
    .pos_valid  (pos_valid),
    .err_missing(err_missing),
    .err_multi  (err_multi)
  );

  typedef struct {
    int         due;
    bit         v;
    bit         mi;
    bit         mu;
    logic [7:0] pos;
  } exp_t;

  exp_t q[$];
  int cyc      = 0;
  int n_assert = 0;
  int n_fail   = 0;
  int n_v  = 0, n_mi = 0, n_mu = 0;
  int e_v  = 0, e_mi = 0, e_mu = 0;

  // Strobe-cycle counters: catch extra or stretched strobes
  always @(negedge clk) begin
    if (pos_valid === 1'b1)   n_v++;
    if (err_missing === 1'b1) n_mi++;
    if (err_multi === 1'b1)   n_mu++;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, observed cyc=%0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: sample #1 after the edge and check any frame result due now
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk($sformatf("pos_valid@%0d", cyc),   32'(pos_valid),   32'(e.v));
      chk($sformatf("err_missing@%0d", cyc), 32'(err_missing), 32'(e.mi));
      chk($sformatf("err_multi@%0d", cyc),   32'(err_multi),   32'(e.mu));
      chk($sformatf("pos_out@%0d", cyc),     32'(pos_out),     32'(e.pos));
    end
  endtask

  // Drive one frame (sync at k=0) of len cycles; two optional pulses, a
  // carried-over high at the start, and an optional ena-low gap before k=eoff_at
  task automatic frame(input int len, input int p1, input int w1,
                       input int p2, input int w2, input int carry,
                       input int eoff_at, input int eoff_len,
                       input bit has_exp, input bit ev, input bit em,
                       input bit eu, input logic [7:0] epos);
    exp_t e;
    int   c0;
    c0 = cyc + 1;
    if (has_exp) begin
      e.due = c0 + 255 + L + eoff_len;
      e.v   = ev;
      e.mi  = em;
      e.mu  = eu;
      e.pos = epos;
      q.push_back(e);
      e_v  += int'(ev);
      e_mi += int'(em);
      e_mu += int'(eu);
    end
    for (int k = 0; k < len; k++) begin
      sync_in = (k == 0);
      ppm_in  = (k >= p1 && k < p1 + w1) || (k >= p2 && k < p2 + w2) || (k < carry);
      if (k == eoff_at && eoff_len > 0) begin
        ena = 1'b0;
        repeat (eoff_len) tick();
        ena = 1'b1;
      end
      tick();
    end
    sync_in = 1'b0;
    ppm_in  = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    ena     = 1'b1;
    ppm_in  = 1'b0;
    sync_in = 1'b0;
    repeat (3) tick();
    chk("reset_pos_out",     32'(pos_out),     32'd0);
    chk("reset_pos_valid",   32'(pos_valid),   32'd0);
    chk("reset_err_missing", 32'(err_missing), 32'd0);
    chk("reset_err_multi",   32'(err_multi),   32'd0);
    rst = 1'b0;

    //     len  p1  w1  p2   w2 car eoff len  exp v  mi mu pos
    frame(256, 100, 4,  0,   0, 0,  -1, 0,   1,  1, 0, 0, 8'd100); // good x3
    frame(256, 100, 4,  0,   0, 0,  -1, 0,   1,  1, 0, 0, 8'd100);
    frame(256, 100, 4,  0,   0, 0,  -1, 0,   1,  1, 0, 0, 8'd100);
    frame(256,  50, 1, 100,  4, 0,  -1, 0,   1,  1, 0, 0, 8'd100); // glitch ignored
    frame(256,   0, 0,  0,   0, 0,  -1, 0,   1,  0, 1, 0, 8'd100); // missing
    frame(256,  30, 4, 200,  4, 0,  -1, 0,   1,  0, 0, 1, 8'd100); // multi
    frame(256,   0, 4,  0,   0, 0,  -1, 0,   1,  1, 0, 0, 8'd0);   // P=0
    frame(256, 255, 4,  0,   0, 0,  -1, 0,   1,  0, 1, 0, 8'd0);   // rise at 255, accepted next frame
    frame(256,   0, 0,  0,   0, 3,  -1, 0,   1,  1, 0, 0, 8'd255);
    frame(256, 254, 4,  0,   0, 0,  -1, 0,   1,  1, 0, 0, 8'd254); // accepted at frame end
    frame(256,   0, 0,  0,   0, 2,  -1, 0,   1,  0, 1, 0, 8'd254); // tail of pulse is not a new hit
    frame(256,  40, 2,  0,   0, 0,  41, 3,   1,  1, 0, 0, 8'd40);  // ena low mid-pulse, exact min width
    frame(128,  60, 4,  0,   0, 0,  -1, 0,   0,  0, 0, 0, 8'd0);   // aborted by early sync
    frame(256,  77, 4,  0,   0, 0,  -1, 0,   1,  1, 0, 0, 8'd77);
    frame( 90,   0, 0,  0,   0, 0,  -1, 0,   0,  0, 0, 0, 8'd0);   // reset lands here

    rst = 1'b1;
    #1;
    chk("rst_mid_pos_out",     32'(pos_out),     32'd0);
    chk("rst_mid_pos_valid",   32'(pos_valid),   32'd0);
    chk("rst_mid_err_missing", 32'(err_missing), 32'd0);
    chk("rst_mid_err_multi",   32'(err_multi),   32'd0);
    tick();
    rst = 1'b0;

    frame(256,  10, 4,  0,   0, 0,  -1, 0,   1,  1, 0, 0, 8'd10);  // decodes after reset
    repeat (L + 4) tick();

    chk("pending_frames", 32'(q.size()), 32'd0);
    chk("count_valid",    32'(n_v),      32'(e_v));
    chk("count_missing",  32'(n_mi),     32'(e_mi));
    chk("count_multi",    32'(n_mu),     32'(e_mu));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
